prbs15_checker: RTL and testbench



---
 rtl/prbs15_pkg.sv | 27 ++
 rtl/prbs15_lfsr.sv | 43 ++++
 rtl/prbs15_checker.sv | 154 +++++++++++++++
 tb/tb_prbs15_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs15_pkg.sv
// rtl/prbs15_pkg.sv - shared constants, state encoding and LFSR step for the PRBS15 checker
package prbs15_pkg;

   localparam int PRBS_W = 15;
   localparam int TAP_HI = 14;
   localparam int TAP_LO = 13;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } prbs_state_e;

   typedef struct packed {
      logic [PRBS_W-1:0] state;
      logic              new_bit;
   } prbs_step_t;

   // One step of the x^15+x^14+1 generator: new bit from the taps, shifted in at bit 0.
   function automatic prbs_step_t prbs15_next(input logic [PRBS_W-1:0] cur);
      prbs_step_t step;
      step.new_bit = cur[TAP_HI] ^ cur[TAP_LO];
      step.state   = {cur[PRBS_W-2:0], step.new_bit};
      return step;
   endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// rtl/prbs15_lfsr.sv - local 15-bit LFSR loaded from the received or the predicted bit
module prbs15_lfsr
   import prbs15_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load_pred,
   input  logic              din,
   output logic [PRBS_W-1:0] r,
   output logic              p
);

   logic [PRBS_W-1:0] r_q;
   logic [PRBS_W-1:0] r_d;
   prbs_step_t        step;

   // Next register value: free-run on the prediction when locked, otherwise follow the line.
   always_comb begin
      step = prbs15_next(r_q);
      r_d  = r_q;
      if (en) begin
         if (load_pred) begin
            r_d = step.state;
         end else begin
            r_d = {r_q[PRBS_W-2:0], din};
         end
      end
   end

   // Register update with synchronous reset to the all-zero state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   assign r = r_q;
   assign p = step.new_bit;

endmodule

// File: rtl/prbs15_checker.sv
// rtl/prbs15_checker.sv - self-synchronising PRBS15 receive checker with lock and error counting
module prbs15_checker
   import prbs15_pkg::*;
#(
   parameter int LOCK_THRESH = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int ERR_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 din_valid,
   input  logic                 din,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int FILL_W  = 4;
   localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
   localparam int WBIT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS_W - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
   localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(LOSS_THRESH);

   prbs_state_e          state_q, state_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [MATCH_W-1:0]   match_q, match_d;
   logic [WBIT_W-1:0]    wbit_q, wbit_d;
   logic [WERR_W-1:0]    werr_q, werr_d;
   logic [WERR_W-1:0]    werr_now;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 err_pulse_q, err_pulse_d;

   logic [PRBS_W-1:0]    r;
   logic                 p;
   logic                 bit_err;
   logic                 r_nonzero;

   prbs15_lfsr u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .en        (din_valid),
      .load_pred (state_q == ST_LOCKED),
      .din       (din),
      .r         (r),
      .p         (p)
   );

   assign bit_err   = din ^ p;
   assign r_nonzero = |r;

   // Sequencing of search/verify/locked plus fill, match, window and error bookkeeping.
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      match_d     = match_q;
      wbit_d      = wbit_q;
      werr_d      = werr_q;
      err_cnt_d   = err_cnt_q;
      err_pulse_d = 1'b0;
      werr_now    = werr_q;

      if (din_valid) begin
         case (state_q)
            ST_SEARCH: begin
               if (fill_q == FILL_LAST) begin
                  state_d = ST_VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end

            ST_VERIFY: begin
               // An all-zero register predicts zeros forever, so it never earns a match.
               if (bit_err || !r_nonzero) begin
                  match_d = '0;
               end else if (match_q == MATCH_LAST) begin
                  state_d = ST_LOCKED;
                  match_d = '0;
                  wbit_d  = '0;
                  werr_d  = '0;
               end else begin
                  match_d = match_q + MATCH_W'(1);
               end
            end

            ST_LOCKED: begin
               if (bit_err) begin
                  err_pulse_d = 1'b1;
                  werr_now    = werr_q + WERR_W'(1);
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                  end
               end
               if (werr_now == WERR_LIMIT) begin
                  state_d = ST_SEARCH;
                  fill_d  = '0;
                  match_d = '0;
                  wbit_d  = '0;
                  werr_d  = '0;
               end else if (wbit_q == WBIT_LAST) begin
                  wbit_d = '0;
                  werr_d = '0;
               end else begin
                  wbit_d = wbit_q + WBIT_W'(1);
                  werr_d = werr_now;
               end
            end

            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end

      // Clear wins over an increment in the same cycle; the pulse is left alone.
      if (clear) begin
         err_cnt_d = '0;
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SEARCH;
         fill_q      <= '0;
         match_q     <= '0;
         wbit_q      <= '0;
         werr_q      <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         wbit_q      <= wbit_d;
         werr_q      <= werr_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = (state_q == ST_LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs15_checker.sv
// tb/tb_prbs15_checker.sv - randomized bench for prbs15_checker against a sequence-level model
module tb_prbs15_checker;

   localparam int LOCK_THRESH = 32;
   localparam int WINDOW      = 64;
   localparam int LOSS_THRESH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        din_valid = 1'b0;
   logic        din = 1'b0;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic        locked_w4, err_pulse_w4;
   logic [3:0]  err_count_w4;

   always #5 clk = ~clk;

   prbs15_checker dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   prbs15_checker #(.ERR_CNT_W(4)) dut_w4 (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked_w4),
      .err_pulse (err_pulse_w4),
      .err_count (err_count_w4)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: last 15 received bits, the free-running expected sequence, and counters.
   int  m_mode;
   int  m_fill, m_match, m_wbit, m_werr;
   int  m_cnt, m_cnt4;
   bit  m_pulse;
   bit  rx_hist[$];
   bit  loc_seq[$];

   logic [14:0] scr;

   task automatic model_reset();
      m_mode = 0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
      m_cnt = 0; m_cnt4 = 0; m_pulse = 1'b0;
      rx_hist.delete();
      for (int i = 0; i < 15; i++) rx_hist.push_back(1'b0);
      loc_seq = rx_hist;
   endtask

   task automatic hist_push(input bit b);
      rx_hist.push_back(b);
      void'(rx_hist.pop_front());
   endtask

   task automatic model_step(input bit v, input bit b, input bit clr);
      bit pred;
      bit any;
      m_pulse = 1'b0;
      if (v) begin
         case (m_mode)
            0: begin
               hist_push(b);
               m_fill++;
               if (m_fill == 15) begin
                  m_mode = 1; m_fill = 0; m_match = 0;
               end
            end
            1: begin
               pred = rx_hist[0] ^ rx_hist[1];
               any  = 1'b0;
               foreach (rx_hist[k]) any |= rx_hist[k];
               hist_push(b);
               if (b == pred && any) begin
                  m_match++;
                  if (m_match == LOCK_THRESH) begin
                     m_mode = 2; m_match = 0; m_wbit = 0; m_werr = 0;
                     loc_seq = rx_hist;
                  end
               end else begin
                  m_match = 0;
               end
            end
            default: begin
               pred = loc_seq[0] ^ loc_seq[1];
               loc_seq.push_back(pred);
               void'(loc_seq.pop_front());
               hist_push(b);
               if (b != pred) begin
                  m_pulse = 1'b1;
                  if (m_cnt < 65535) m_cnt++;
                  if (m_cnt4 < 15) m_cnt4++;
                  m_werr++;
               end
               if (m_werr >= LOSS_THRESH) begin
                  m_mode = 0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
               end else begin
                  m_wbit++;
                  if (m_wbit == WINDOW) begin
                     m_wbit = 0; m_werr = 0;
                  end
               end
            end
         endcase
      end
      if (clr) begin
         m_cnt = 0; m_cnt4 = 0;
      end
   endtask

   task automatic compare_outputs();
      check_eq("locked", locked, m_mode == 2);
      check_eq("err_pulse", err_pulse, m_pulse);
      check_eq("err_count", err_count, m_cnt);
      check_eq("locked_w4", locked_w4, m_mode == 2);
      check_eq("err_pulse_w4", err_pulse_w4, m_pulse);
      check_eq("err_count_w4", err_count_w4, m_cnt4);
   endtask

   task automatic cyc(input bit v, input bit b, input bit clr);
      din_valid = v; din = b; clear = clr;
      @(posedge clk);
      model_step(v, b, clr);
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1; din_valid = 1'($urandom); din = 1'($urandom); clear = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      compare_outputs();
      rst = 1'b0;
   endtask

   // Upstream scrambler bit, optionally corrupted on the line; invalid cycles carry junk.
   task automatic send(input bit v, input bit flip, input bit clr);
      bit b;
      if (v) begin
         b   = scr[14] ^ scr[13];
         scr = {scr[13:0], b};
         b   = b ^ flip;
      end else begin
         b = 1'($urandom);
      end
      cyc(v, b, clr);
   endtask

   int lock_at, drop_at, relock_at, pulses, seen, cnt, last_err, gap;
   bit err_mask[64];

   initial begin
      // Correct stream from seed 1: lock on valid bit 47, no errors over 1000 bits.
      scr = 15'h0001;
      do_reset();
      lock_at = -1;
      for (int i = 1; i <= 1000; i++) begin
         send(1'b1, 1'b0, 1'b0);
         if (locked && lock_at < 0) lock_at = i;
      end
      check_eq("lock_at_bit", lock_at, 47);
      check_eq("clean_err_count", err_count, 0);

      // One flipped bit while locked: exactly one pulse and count.
      pulses = 0;
      cnt = $urandom_range(5, 50);
      for (int i = 0; i < 200; i++) begin
         send(1'b1, i == cnt, 1'b0);
         pulses += int'(err_pulse);
      end
      check_eq("single_err_pulses", pulses, 1);
      check_eq("single_err_count", err_count, 1);
      check_eq("single_err_locked", locked, 1);

      // All-zero line never locks.
      do_reset();
      seen = 0;
      for (int i = 0; i < 500; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         seen += int'(locked);
      end
      check_eq("zero_stream_locked_cycles", seen, 0);

      // Eight errors within the first window after lock drop lock on the eighth, then relock.
      scr = 15'($urandom_range(1, 32767));
      do_reset();
      lock_at = -1;
      for (int i = 1; i <= 200 && lock_at < 0; i++) begin
         send(1'b1, 1'b0, 1'b0);
         if (locked) lock_at = i;
      end
      check_eq("lock2_at_bit", lock_at, 47);
      foreach (err_mask[k]) err_mask[k] = 1'b0;
      cnt = 0;
      while (cnt < 8) begin
         gap = $urandom_range(0, 63);
         if (!err_mask[gap]) begin
            err_mask[gap] = 1'b1;
            cnt++;
         end
      end
      last_err = 0;
      foreach (err_mask[k]) if (err_mask[k]) last_err = k;
      drop_at = -1; relock_at = -1; pulses = 0;
      for (int i = 0; i < 300 && relock_at < 0; i++) begin
         send(1'b1, (i < 64) ? err_mask[i] : 1'b0, 1'b0);
         pulses += int'(err_pulse);
         if (!locked && drop_at < 0) drop_at = i;
         if (locked && drop_at >= 0) relock_at = i;
      end
      check_eq("drop_on_eighth_err", drop_at, last_err);
      check_eq("burst_err_count", err_count, 8);
      check_eq("burst_err_count_w4", err_count_w4, 8);
      check_eq("burst_pulses", pulses, 8);
      check_eq("relock_distance", relock_at - drop_at, 47);

      // Valid on every other cycle: lock after 94 cycles.
      scr = 15'($urandom_range(1, 32767));
      do_reset();
      lock_at = -1;
      for (int c = 1; c <= 300; c++) begin
         send(c % 2 == 0, 1'b0, 1'b0);
         if (locked && lock_at < 0) lock_at = c;
      end
      check_eq("toggle_lock_cycle", lock_at, 94);

      // Twenty spaced errors under random valid gaps: 4-bit count saturates at 15.
      for (int e = 0; e < 20; e++) begin
         gap = $urandom_range(20, 30);
         while (gap > 0) begin
            if ($urandom_range(0, 3) != 0) begin
               send(1'b1, 1'b0, 1'b0);
               gap--;
            end else begin
               send(1'b0, 1'b0, 1'b0);
            end
         end
         send(1'b1, 1'b1, 1'b0);
      end
      check_eq("sat_err_count", err_count, 20);
      check_eq("sat_err_count_w4", err_count_w4, 15);
      check_eq("sat_locked", locked, 1);

      // Clear coinciding with an error: count zero, pulse still fires.
      send(1'b1, 1'b1, 1'b1);
      check_eq("clear_err_count", err_count, 0);
      check_eq("clear_err_count_w4", err_count_w4, 0);
      check_eq("clear_err_pulse", err_pulse, 1);
      for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 1'b0);

      // Reset while locked discards everything.
      do_reset();
      check_eq("rst_locked", locked, 0);
      check_eq("rst_err_count", err_count, 0);
      for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
